// File: rtl/reg_a_feed_fifo.sv
// Request FIFO feeding register A: buffers pushed words and hands them out
// one per pop as a registered one-cycle load strobe plus data word.
module reg_a_feed_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_ready,
   input  logic             clr_ovf,
   output logic             loadA,
   output logic [WIDTH-1:0] dataAin,
   output logic             full,
   output logic             empty,
   output logic [PTR_W:0]   count,
   output logic             overflow
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic [PTR_W:0]   count_nxt_s;
   logic             push_s;
   logic             pop_s;
   logic             load_r;
   logic [WIDTH-1:0] data_r;
   logic             ovf_r;

   // Status flags are decoded from the registered occupancy count.
   always_comb begin
      full     = (count_r == (PTR_W+1)'(DEPTH));
      empty    = (count_r == (PTR_W+1)'(0));
      count    = count_r;
      loadA    = load_r;
      dataAin  = data_r;
      overflow = ovf_r;
      push_s   = wr_en & ~full;
      pop_s    = rd_ready & ~empty;
   end

   // Occupancy changes only when exactly one of push/pop happens.
   always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + (PTR_W+1)'(1);
         2'b01:   count_nxt_s = count_r - (PTR_W+1)'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Storage array: contents are don't-care after reset, so it carries none.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers, occupancy and the registered load interface to register A.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {(PTR_W+1){1'b0}};
         load_r   <= 1'b0;
         data_r   <= {WIDTH{1'b0}};
      end else begin
         count_r <= count_nxt_s;
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            load_r   <= 1'b1;
            data_r   <= mem_r[rd_ptr_r];
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end else begin
            load_r <= 1'b0;
         end
      end
   end

   // Sticky overflow; a rejected push on the same edge as a clear keeps it set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
      end else if (wr_en & full) begin
         ovf_r <= 1'b1;
      end else if (clr_ovf) begin
         ovf_r <= 1'b0;
      end else begin
         ovf_r <= ovf_r;
      end
   end

endmodule

// File: tb/tb_reg_a_feed_fifo.sv
// Directed self-checking bench for reg_a_feed_fifo with hand-computed
// expected values for reset, ordering, overflow and wrap-around.
module tb_reg_a_feed_fifo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [15:0] wr_data;
   logic        rd_ready;
   logic        clr_ovf;
   logic        loadA;
   logic [15:0] dataAin;
   logic        full;
   logic        empty;
   logic [2:0]  count;
   logic        overflow;

   int n_checks = 0;
   int n_fail   = 0;

   reg_a_feed_fifo #(.WIDTH(16), .DEPTH(4), .PTR_W(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_ready (rd_ready),
      .clr_ovf  (clr_ovf),
      .loadA    (loadA),
      .dataAin  (dataAin),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      step();
      wr_en   = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      wr_en    = 1'b0;
      wr_data  = 16'h0000;
      rd_ready = 1'b0;
      clr_ovf  = 1'b0;
      #12;
      check_eq("rst_empty", 32'(empty), 32'd1);
      check_eq("rst_full", 32'(full), 32'd0);
      check_eq("rst_count", 32'(count), 32'd0);
      check_eq("rst_loadA", 32'(loadA), 32'd0);
      check_eq("rst_dataAin", 32'(dataAin), 32'h0000);
      check_eq("rst_ovf", 32'(overflow), 32'd0);
      rst_n = 1'b1;

      // Single word with rd_ready held high
      rd_ready = 1'b1;
      push(16'h00FE);
      check_eq("sw_count1", 32'(count), 32'd1);
      check_eq("sw_nobypass", 32'(loadA), 32'd0);
      step();
      check_eq("sw_loadA", 32'(loadA), 32'd1);
      check_eq("sw_data", 32'(dataAin), 32'h00FE);
      check_eq("sw_count0", 32'(count), 32'd0);
      step();
      check_eq("sw_loadA_drop", 32'(loadA), 32'd0);
      check_eq("sw_data_hold", 32'(dataAin), 32'h00FE);
      check_eq("sw_empty", 32'(empty), 32'd1);

      // Fill, overflow, drain, clear
      rd_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         push(16'(i));
         check_eq("fill_count", 32'(count), 32'(i));
      end
      check_eq("fill_full", 32'(full), 32'd1);
      push(16'h0005);
      check_eq("ovf_set", 32'(overflow), 32'd1);
      check_eq("ovf_count", 32'(count), 32'd4);
      rd_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         check_eq("drain_loadA", 32'(loadA), 32'd1);
         check_eq("drain_data", 32'(dataAin), 32'(i));
      end
      check_eq("drain_count", 32'(count), 32'd0);
      step();
      check_eq("drain_no5", 32'(loadA), 32'd0);
      check_eq("drain_ovf_sticky", 32'(overflow), 32'd1);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      check_eq("ovf_clr", 32'(overflow), 32'd0);

      // Simultaneous push and pop at count=2
      rd_ready = 1'b0;
      push(16'h0011);
      push(16'h0022);
      rd_ready = 1'b1;
      push(16'h0FE6);
      check_eq("sim_count", 32'(count), 32'd2);
      check_eq("sim_loadA", 32'(loadA), 32'd1);
      check_eq("sim_data", 32'(dataAin), 32'h0011);
      rd_ready = 1'b0;
      push(16'h0033);
      push(16'h0044);
      check_eq("sim_full", 32'(full), 32'd1);
      // Full: push rejected while pop proceeds; set beats clear
      rd_ready = 1'b1;
      clr_ovf  = 1'b1;
      push(16'h0055);
      clr_ovf  = 1'b0;
      check_eq("full_pp_count", 32'(count), 32'd3);
      check_eq("full_pp_ovf", 32'(overflow), 32'd1);
      check_eq("full_pp_data", 32'(dataAin), 32'h0022);
      step();
      check_eq("full_pp_d1", 32'(dataAin), 32'h0FE6);
      step();
      check_eq("full_pp_d2", 32'(dataAin), 32'h0033);
      step();
      check_eq("full_pp_d3", 32'(dataAin), 32'h0044);
      check_eq("full_pp_ld3", 32'(loadA), 32'd1);
      step();
      check_eq("full_pp_no55", 32'(loadA), 32'd0);
      check_eq("full_pp_empty", 32'(empty), 32'd1);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;

      // Wrap-around: 10 words, occupancy builds to 3, pointers wrap twice
      rd_ready = 1'b0;
      for (int i = 0; i < 3; i++) push(16'hA000 + 16'(i));
      check_eq("wrap_count3", 32'(count), 32'd3);
      rd_ready = 1'b1;
      for (int i = 3; i < 10; i++) begin
         push(16'hA000 + 16'(i));
         check_eq("wrap_ld", 32'(loadA), 32'd1);
         check_eq("wrap_data", 32'(dataAin), 32'hA000 + 32'(i - 3));
         check_eq("wrap_cnt", 32'(count), 32'd3);
      end
      for (int k = 7; k < 10; k++) begin
         step();
         check_eq("wrap_tail_ld", 32'(loadA), 32'd1);
         check_eq("wrap_tail_data", 32'(dataAin), 32'hA000 + 32'(k));
      end
      step();
      check_eq("wrap_end_ld", 32'(loadA), 32'd0);
      check_eq("wrap_end_empty", 32'(empty), 32'd1);

      // Reset during a load cycle
      rd_ready = 1'b0;
      push(16'h00B1);
      push(16'h00B2);
      push(16'h00B3);
      rd_ready = 1'b1;
      step();
      check_eq("mr_ld", 32'(loadA), 32'd1);
      check_eq("mr_data", 32'(dataAin), 32'h00B1);
      #3;
      rst_n = 1'b0;
      #1;
      check_eq("mr_loadA", 32'(loadA), 32'd0);
      check_eq("mr_count", 32'(count), 32'd0);
      check_eq("mr_empty", 32'(empty), 32'd1);
      check_eq("mr_data0", 32'(dataAin), 32'h0000);
      #3;
      rst_n = 1'b1;
      push(16'h1234);
      check_eq("mr_push_cnt", 32'(count), 32'd1);
      step();
      check_eq("mr_new_ld", 32'(loadA), 32'd1);
      check_eq("mr_new_data", 32'(dataAin), 32'h1234);
      step();
      check_eq("mr_new_drop", 32'(loadA), 32'd0);
      check_eq("mr_new_empty", 32'(empty), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_a_feed_fifo.md
Name: reg_a_feed_fifo

Overview:
Small synchronous request FIFO that buffers 16-bit words from the command-capture logic and delivers them one at a time into register A. It sits directly upstream of register A. Each accepted word is presented as a one-cycle load pulse plus data, so register A captures exactly one word per pop. It decouples bursty producers from the register's single-word load interface and reports fill level and overflow.

Parameters:
WIDTH, 16, data word width
DEPTH, 4, number of entries; power of 2, minimum 2
PTR_W, 2, log2(DEPTH); pointer width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  push request
wr_data  input  WIDTH  word to push
rd_ready  input  1  downstream may accept a word this cycle
clr_ovf  input  1  synchronous clear of sticky overflow flag
loadA  output  1  one-cycle load strobe to register A
dataAin  output  WIDTH  word for register A; valid while loadA=1
full  output  1  count==DEPTH
empty  output  1  count==0
count  output  PTR_W+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: push attempted while full

Behaviour:
- Reset (rst_n=0, async): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, loadA=0, dataAin=0, overflow=0. Storage array is not cleared; its contents are don't-care.
- Reset asserted mid-operation discards all buffered words immediately, with no load pulse. The first rising edge after rst_n deasserts behaves as normal operation.
- push = wr_en & ~full. The word is written at mem[wr_ptr] and wr_ptr increments modulo DEPTH.
- pop = rd_ready & ~empty. On the edge, loadA<=1 and dataAin<=mem[rd_ptr], then rd_ptr increments modulo DEPTH.
- loadA and dataAin are registered outputs.
- If no pop occurs on an edge, loadA<=0 and dataAin holds its previous value.
- Back-to-back pops give consecutive loadA=1 cycles, each with a new dataAin.
- count update per edge: +1 on push only, -1 on pop only, unchanged on both or neither.
- full and empty are decoded from registered count.
- Simultaneous push and pop at 0<count<DEPTH: both occur and count is unchanged.
- Push when empty: no bypass. The word is written, empty deasserts after the edge, and the earliest pop is on the next edge.
- Push when full is rejected even if a pop happens on the same edge. The word is dropped and overflow<=1.
- Pop when empty is ignored. loadA stays 0 and no state changes.
- overflow is sticky. It is cleared only by clr_ovf=1 at an edge or by reset. If clr_ovf and a rejected push occur on the same edge, overflow=1 (set wins).
- Latency from a push at edge N with rd_ready held 1: pop at edge N+1, loadA=1 during cycle N+1..N+2, register A captures at edge N+2.
- Ordering is strictly first-in first-out. Pointer wrap-around is invisible at the ports.

Test Plan:
- Reset check: drive rst_n=0 asynchronously mid-cycle → all outputs immediately at reset values (empty=1, count=0, loadA=0, dataAin=16'h0000, overflow=0).
- Single word: push 16'h00FE at edge N with rd_ready=1 → loadA=1 and dataAin=16'h00FE for exactly one cycle after edge N+1; count goes 1 then 0; empty=1 afterwards.
- Fill and overflow: rd_ready=0, push 16'h0001..16'h0004 → full=1, count=4. Push 16'h0005 → rejected, overflow=1, count=4. Then rd_ready=1 → four consecutive loadA pulses carrying 0001, 0002, 0003, 0004; the dropped 0005 never appears. clr_ovf → overflow=0.
- Simultaneous push and pop: at count=2 with rd_ready=1, push 16'h0FE6 → count stays 2 and the pop delivers the oldest word. With count=4 (full), wr_en=1 and rd_ready=1 on the same edge → pop occurs, push rejected, count=3, overflow=1.
- Wrap-around: 10 push/pop pairs of 16'hA000+i with occupancy cycling 0..3 → output order matches input order, and no pulse is lost or duplicated across pointer wrap.
- Reset mid-burst: three words queued, rst_n pulsed low during the loadA cycle → loadA drops immediately, count=0. A new push of 16'h1234 afterwards is the next word delivered.
